sim_harness_ctrl: RTL and testbench

SIM_HARNESS_CTRL -- requirements
Module: sim_harness_ctrl

---
 rtl/sim_harness_ctrl.sv | 121 ++++++++++++
 tb/tb_sim_harness_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sim_harness_ctrl.sv
// Test-harness controller: sequences the core reset, watches stores to the
// tohost word and reports PASS / FAIL / TIMEOUT with a saturating RUN-cycle count.
module sim_harness_ctrl #(
  parameter int               XLEN           = 32,
  parameter int               RESET_CYCLES   = 3,
  parameter logic [XLEN-1:0]  TOHOST_ADDR    = XLEN'('h0FFC),
  parameter int               TIMEOUT_CYCLES = 100000,
  parameter int               CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             core_reset,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [XLEN-2:0]  fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam int               HW        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic             TO_EN     = (TIMEOUT_CYCLES != 0);

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-2:0]  fail_q, fail_d;
  logic             core_reset_q, core_reset_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic             tohost;

  assign tohost = mem_we && (mem_addr == TOHOST_ADDR);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    case (state_q)
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_RUN;
        else                     hold_d  = hold_q + HW'(1);
      end
      S_RUN: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        // A qualifying store on the timeout cycle wins over the timeout.
        if (tohost && mem_wdata[0]) begin
          if (mem_wdata[XLEN-1:1] == '0) begin
            state_d = S_PASS;
          end else begin
            state_d = S_FAIL;
            fail_d  = mem_wdata[XLEN-1:1];
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d = S_TIMEOUT;
        end
      end
      S_PASS, S_FAIL, S_TIMEOUT: begin
        if (restart) begin
          state_d = S_HOLD;
          hold_d  = '0;
          cnt_d   = '0;
          fail_d  = '0;
        end
      end
      default: state_d = S_HOLD;
    endcase

    core_reset_d = (state_d == S_HOLD);
    pass_d       = (state_d == S_PASS);
    timeout_d    = (state_d == S_TIMEOUT);
    done_d       = (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_HOLD;
      hold_q       <= '0;
      cnt_q        <= '0;
      fail_q       <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      fail_q       <= fail_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
    end
  end

  assign core_reset  = core_reset_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_code   = fail_q;
  assign cycle_count = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sim_harness_ctrl.sv
// Directed bench for sim_harness_ctrl: one default instance (a_*) for reset,
// PASS, FAIL, restart and async reset; one with TIMEOUT_CYCLES=20 (b_*).
module tb_sim_harness_ctrl;

  logic        clk;
  logic        reset;
  logic        a_restart, a_we;
  logic [31:0] a_addr, a_wdata;
  logic        a_core_reset, a_done, a_pass, a_timeout;
  logic [30:0] a_fail_code;
  logic [31:0] a_cnt;
  logic [2:0]  a_state;
  logic        b_restart, b_we;
  logic [31:0] b_addr, b_wdata;
  logic        b_core_reset, b_done, b_pass, b_timeout;
  logic [30:0] b_fail_code;
  logic [31:0] b_cnt;
  logic [2:0]  b_state;

  int n_checks = 0;
  int n_errors = 0;

  sim_harness_ctrl dut_a (
    .clk(clk), .reset(reset), .restart(a_restart), .mem_we(a_we),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .core_reset(a_core_reset),
    .done(a_done), .pass(a_pass), .timeout(a_timeout), .fail_code(a_fail_code),
    .cycle_count(a_cnt), .dbg_state(a_state)
  );

  sim_harness_ctrl #(.TIMEOUT_CYCLES(20)) dut_b (
    .clk(clk), .reset(reset), .restart(b_restart), .mem_we(b_we),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .core_reset(b_core_reset),
    .done(b_done), .pass(b_pass), .timeout(b_timeout), .fail_code(b_fail_code),
    .cycle_count(b_cnt), .dbg_state(b_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_store(input logic [31:0] addr, input logic [31:0] data);
    a_we = 1'b1; a_addr = addr; a_wdata = data;
    tick();
    a_we = 1'b0; a_addr = '0; a_wdata = '0;
  endtask

  task automatic a_wait_cnt(input int target);
    for (int i = 0; i < 300; i++) begin
      if (a_cnt == 32'(target)) break;
      tick();
    end
    check("a_wait_cnt", 64'(a_cnt), 64'(target));
  endtask

  task automatic b_wait_cnt(input int target);
    for (int i = 0; i < 300; i++) begin
      if (b_cnt == 32'(target)) break;
      tick();
    end
    check("b_wait_cnt", 64'(b_cnt), 64'(target));
  endtask

  initial begin
    reset = 1'b1;
    a_restart = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_restart = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

    // reset values
    #2;
    check("rst_core_reset", 64'(a_core_reset), 64'd1);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_pass", 64'(a_pass), 64'd0);
    check("rst_timeout", 64'(a_timeout), 64'd0);
    check("rst_fail_code", 64'(a_fail_code), 64'd0);
    check("rst_cnt", 64'(a_cnt), 64'd0);
    check("rst_state", 64'(a_state), 64'd0);
    tick();
    tick();
    reset = 1'b0;

    // core_reset hold sequence
    check("hold_pre_e0", 64'(a_core_reset), 64'd1);
    tick();
    check("hold_e0", 64'(a_core_reset), 64'd1);
    tick();
    check("hold_e1", 64'(a_core_reset), 64'd1);
    tick();
    check("hold_e2_core_reset", 64'(a_core_reset), 64'd0);
    check("hold_e2_cnt", 64'(a_cnt), 64'd0);
    check("hold_e2_state", 64'(a_state), 64'd1);
    tick();
    check("run_e3_cnt", 64'(a_cnt), 64'd1);

    // restart and even-data tohost store are ignored in RUN
    a_wait_cnt(5);
    a_restart = 1'b1;
    tick();
    a_restart = 1'b0;
    check("restart_run_done", 64'(a_done), 64'd0);
    check("restart_run_core_reset", 64'(a_core_reset), 64'd0);
    check("restart_run_cnt", 64'(a_cnt), 64'd6);
    a_store(32'h0FFC, 32'h2);
    check("even_store_done", 64'(a_done), 64'd0);
    check("even_store_cnt", 64'(a_cnt), 64'd7);

    // PASS on the 10th RUN edge
    a_wait_cnt(9);
    a_store(32'h0FFC, 32'h1);
    check("pass_pass", 64'(a_pass), 64'd1);
    check("pass_done", 64'(a_done), 64'd1);
    check("pass_timeout", 64'(a_timeout), 64'd0);
    check("pass_cnt", 64'(a_cnt), 64'd10);
    check("pass_state", 64'(a_state), 64'd2);
    tick(); tick(); tick();
    a_store(32'h0FFC, 32'h7);
    check("pass_frozen_cnt", 64'(a_cnt), 64'd10);
    check("pass_hold", 64'(a_pass), 64'd1);
    check("pass_store_ignored", 64'(a_fail_code), 64'd0);
    check("pass_core_reset", 64'(a_core_reset), 64'd0);

    // restart from PASS: 3 edges of core_reset, stores in HOLD ignored
    a_restart = 1'b1;
    tick();
    a_restart = 1'b0;
    check("rs_core_reset", 64'(a_core_reset), 64'd1);
    check("rs_cnt", 64'(a_cnt), 64'd0);
    check("rs_done", 64'(a_done), 64'd0);
    check("rs_pass", 64'(a_pass), 64'd0);
    a_we = 1'b1; a_addr = 32'h0FFC; a_wdata = 32'h1;
    tick();
    check("rs_e1", 64'(a_core_reset), 64'd1);
    tick();
    check("rs_e2", 64'(a_core_reset), 64'd1);
    tick();
    a_we = 1'b0; a_addr = '0; a_wdata = '0;
    check("rs_e3", 64'(a_core_reset), 64'd0);
    check("rs_hold_store_ignored", 64'(a_done), 64'd0);

    // wrong address ignored, then FAIL with code 3
    a_store(32'h0FF8, 32'h1);
    check("wrong_addr_done", 64'(a_done), 64'd0);
    check("wrong_addr_cnt", 64'(a_cnt), 64'd1);
    a_store(32'h0FFC, 32'h7);
    check("fail_done", 64'(a_done), 64'd1);
    check("fail_pass", 64'(a_pass), 64'd0);
    check("fail_timeout", 64'(a_timeout), 64'd0);
    check("fail_code", 64'(a_fail_code), 64'd3);
    check("fail_state", 64'(a_state), 64'd3);
    check("fail_cnt", 64'(a_cnt), 64'd2);

    // restart clears fail_code; async reset mid-RUN
    a_restart = 1'b1;
    tick();
    a_restart = 1'b0;
    check("rs_fail_code", 64'(a_fail_code), 64'd0);
    check("rs_fail_core_reset", 64'(a_core_reset), 64'd1);
    a_wait_cnt(50);
    #2;
    reset = 1'b1;
    #1;
    check("async_core_reset", 64'(a_core_reset), 64'd1);
    check("async_cnt", 64'(a_cnt), 64'd0);
    check("async_done", 64'(a_done), 64'd0);
    check("async_state", 64'(a_state), 64'd0);
    tick();
    reset = 1'b0;

    // timeout instance
    b_wait_cnt(19);
    check("to_pre_timeout", 64'(b_timeout), 64'd0);
    check("to_pre_done", 64'(b_done), 64'd0);
    tick();
    check("to_timeout", 64'(b_timeout), 64'd1);
    check("to_done", 64'(b_done), 64'd1);
    check("to_pass", 64'(b_pass), 64'd0);
    check("to_cnt", 64'(b_cnt), 64'd20);
    check("to_state", 64'(b_state), 64'd4);
    tick(); tick(); tick();
    check("to_frozen_cnt", 64'(b_cnt), 64'd20);
    check("to_core_reset", 64'(b_core_reset), 64'd0);
    b_restart = 1'b1;
    tick();
    b_restart = 1'b0;
    check("to_rs_timeout", 64'(b_timeout), 64'd0);
    b_wait_cnt(19);
    b_we = 1'b1; b_addr = 32'h0FFC; b_wdata = 32'h1;
    tick();
    b_we = 1'b0; b_addr = '0; b_wdata = '0;
    check("to_prio_pass", 64'(b_pass), 64'd1);
    check("to_prio_timeout", 64'(b_timeout), 64'd0);
    check("to_prio_done", 64'(b_done), 64'd1);
    check("to_prio_fail_code", 64'(b_fail_code), 64'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
